// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b, LSB first, one full-subtractor cell with a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             zero_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bo_q, bo_d, ov_q, ov_d, z_q, z_d;
  logic d, br_n, last;
  always_comb begin
    d       = a_q[0] ^ b_q[0] ^ br_q;
    br_n    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    z_d     = z_q;
    if (state_q == IDLE && start_i) begin
      state_d = RUN;
      a_d     = a_i;
      b_d     = b_i;
      cnt_d   = '0;
      br_d    = 1'b0;
    end else if (state_q == RUN) begin
      res_d = {d, res_q[WIDTH-1:1]};
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = br_n;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        // On the MSB cell the shift-reg LSBs are the operand sign bits.
        state_d = DONE;
        diff_d  = res_d;
        bo_d    = br_n;
        ov_d    = (a_q[0] ^ b_q[0]) & (d ^ a_q[0]);
        z_d     = res_d == '0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
    end
  end
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign diff_o     = diff_q;
  assign borrow_o   = bo_q;
  assign overflow_o = ov_q;
  assign zero_o     = z_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the serial subtractor with hand-computed results.
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [15:0] a = '0, b = '0, diff;
  logic busy, done, borrow, overflow, zero;
  int n_cmp = 0, n_err = 0;
  int k, bc, dc;
  logic [15:0] cap;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(16)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .diff_o(diff), .borrow_o(borrow),
    .overflow_o(overflow), .zero_o(zero)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [15:0] av, bv, ed,
                        input logic eb, eo, ez);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, k, 16);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_zero"}, zero, ez);
    tick();
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold"}, diff, ed);
  endtask
  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_zero", zero, 1);
    run_op("t1", 16'd5, 16'd3, 16'h0002, 0, 0, 0);
    run_op("t2", 16'd3, 16'd5, 16'hFFFE, 1, 0, 0);
    run_op("t3a", 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0);
    run_op("t3b", 16'h7FFF, 16'hFFFF, 16'h8000, 1, 1, 0);
    run_op("t4a", 16'h1234, 16'h1234, 16'h0000, 0, 0, 1);
    run_op("t4b", 16'h0000, 16'hFFFF, 16'h0001, 1, 0, 0);
    // start pulsed mid-RUN with new operands must be ignored
    a = 16'd9;
    b = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    dc = 0;
    cap = '0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        cap = diff;
      end
      if (i == 4) begin
        start = 1'b1;
        a = 16'd1;
        b = 16'd1;
      end else start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("t5_diff", cap, 16'h0005);
    chk("t5_busy_cycles", bc, 17);
    chk("t5_done_pulses", dc, 1);
    chk("t5_idle", busy, 0);
    // reset mid-RUN discards the operation
    a = 16'h4321;
    b = 16'h0123;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("t6_running", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_diff", diff, 0);
    chk("t6_zero", zero, 1);
    chk("t6_done", done, 0);
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dc++;
      tick();
    end
    chk("t6_no_done", dc, 0);
    run_op("t6b", 16'd10, 16'd10, 16'h0000, 0, 0, 1);
    // start and reset together: reset wins
    a = 16'd7;
    b = 16'd2;
    start = 1'b1;
    rst = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    chk("t7_busy", busy, 0);
    tick();
    chk("t7_still_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
